vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Pixel-clock display timing generator that sits directly upstream of the cube renderer in top_cube_no_pll. It produces the beam coordinates, data-enable, sync and frame/line strobes that the renderer consumes to build vga_r/g/b/hs/vs. It holds idle until the pixel clock source reports lock, then free-runs one pixel per clk_pix cycle.

Parameters:
CORDW, 10, coordinate bit width for sx/sy (must hold H_TOTAL-1 and V_TOTAL-1)
H_RES, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_RES, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
FCNTW, 16, frame counter width

Ports:
clk_pix  input  1  pixel clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
clk_locked  input  1  pixel clock source locked; low = hold idle
sx  output  CORDW  current horizontal position
sy  output  CORDW  current vertical position
de  output  1  data enable; high when sx<H_RES and sy<V_RES
hs  output  1  horizontal sync at SYNC_POL level while active
vs  output  1  vertical sync at SYNC_POL level while active
line  output  1  one-cycle strobe at sx==0 of every line
frame  output  1  one-cycle strobe at sx==0, sy==0
frame_cnt  output  FCNTW  index of the current frame, starting at 0

Behaviour:
- Derived: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525).
- All outputs registered. sx, sy, de, hs, vs, line and frame in one cycle all describe the same pixel (no skew between them).
- States: IDLE, RUN.
- Reset (rst low, async): state=IDLE, sx=0, sy=0, de=0, hs=vs=!SYNC_POL (inactive), line=0, frame=0, frame_cnt=0.
- IDLE: outputs hold their reset values. On the first edge with clk_locked=1, go to RUN and present (0,0): de=1, line=1, frame=1, frame_cnt=0. Latency is one clk_pix edge from lock.
- RUN, each edge: sx increments. When sx==H_TOTAL-1, sx wraps to 0 and sy increments. When sy==V_TOTAL-1 at that point, sy wraps to 0 and frame_cnt increments modulo 2^FCNTW.
- hs is active for H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (656..751). vs is active for V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (490..491) across whole lines. Both are inactive otherwise.
- line=1 exactly when sx==0. frame=1 exactly when sx==0 and sy==0. Each strobe lasts one cycle.
- clk_locked falling while in RUN: on the next edge return to IDLE and restore the reset values, including frame_cnt=0. When lock returns, restart at (0,0) as above.
- Async reset mid-frame: outputs take reset values immediately, without waiting for an edge.
- Width rule: sx/sy comparisons are unsigned at CORDW. Counters must never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
1. Hold rst low for 3 cycles with clk_locked=1, then release -> while in reset sx=sy=0, de=0, hs=vs=1, frame=0. First edge after release gives sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=0.
2. Run one line with defaults -> de high for sx 0..639 (640 cycles), hs low for sx 656..751 (96 cycles), sx wraps 799->0 with sy 0->1, line pulses every 800 cycles.
3. Run one full frame -> vs low for sy 490..491 (1600 cycles), de=0 for all sy>=480, frame pulses again 420000 cycles after the first, frame_cnt becomes 1.
4. Drop clk_locked at sx=300, sy=200 -> next edge gives sx=sy=0, de=0, hs=vs=1, frame_cnt=0. Re-raise clk_locked -> next edge gives frame=1 at (0,0).
5. Small-timing instance (H_RES=4, H_FP=1, H_SYNC=1, H_BP=1, V_RES=2, V_FP=1, V_SYNC=1, V_BP=1, FCNTW=2, SYNC_POL=1) for 5 frames -> frame period 35 cycles, hs high only at sx=5, frame_cnt sequence 0,1,2,3,0.
6. Assert rst low mid-line at sx=100 between edges -> outputs reach reset values before the next clk_pix edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Pixel-clock display timing generator: beam position, data enable, syncs and
// line/frame strobes, all registered so every output describes the same pixel.
module vga_timing_gen #(
   parameter int CORDW    = 10,
   parameter int H_RES    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_RES    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int FCNTW    = 16
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic             clk_locked,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             de,
   output logic             hs,
   output logic             vs,
   output logic             line,
   output logic             frame,
   output logic [FCNTW-1:0] frame_cnt
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] H_VIS  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_VIS  = CORDW'(V_RES);
   localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
   localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);
   localparam logic             SYNC_ON = (SYNC_POL != 0);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [FCNTW-1:0] fcnt_q, fcnt_d;
   logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic             line_q, line_d, frame_q, frame_d;
   logic             run_d;

   // Outputs are decoded from the next position, so registering them together
   // keeps sx/sy and every strobe aligned on the same pixel.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      sx_d    = '0;
      sy_d    = '0;
      fcnt_d  = '0;
      run_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (clk_locked) begin
               state_d = RUN;
               run_d   = 1'b1;
            end
         end
         RUN: begin
            if (clk_locked) begin
               run_d  = 1'b1;
               fcnt_d = fcnt_q;
               if (sx_q == H_LAST) begin
                  if (sy_q == V_LAST) begin
                     fcnt_d = fcnt_q + FCNTW'(1);
                  end else begin
                     sy_d = sy_q + CORDW'(1);
                  end
               end else begin
                  sx_d = sx_q + CORDW'(1);
                  sy_d = sy_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      de_d    = run_d && (sx_d < H_VIS) && (sy_d < V_VIS);
      hs_d    = (run_d && (sx_d >= HS_BEG) && (sx_d < HS_END)) ? SYNC_ON : !SYNC_ON;
      vs_d    = (run_d && (sy_d >= VS_BEG) && (sy_d < VS_END)) ? SYNC_ON : !SYNC_ON;
      line_d  = run_d && (sx_d == '0);
      frame_d = line_d && (sy_d == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update from the same pre-edge values.
   always_ff @(posedge clk_pix or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sx_q    <= '0;
         sy_q    <= '0;
         fcnt_q  <= '0;
         de_q    <= 1'b0;
         hs_q    <= !SYNC_ON;
         vs_q    <= !SYNC_ON;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         fcnt_q  <= fcnt_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign sx        = sx_q;
   assign sy        = sy_q;
   assign de        = de_q;
   assign hs        = hs_q;
   assign vs        = vs_q;
   assign line      = line_q;
   assign frame     = frame_q;
   assign frame_cnt = fcnt_q;

endmodule
